// File: rtl/keypad_number_entry.sv
// Keypad scanner and 3-digit numeric entry.
// Scans a 4x4 active-low matrix one row per scan tick, debounces a single key,
// edits a BCD entry buffer on commit and converts the buffer to binary on ENTER.
module keypad_number_entry #(
   parameter int unsigned SCAN_DIV       = 5000,
   parameter int unsigned DEBOUNCE_TICKS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [3:0]  key_col,
   output logic [3:0]  key_row,
   output logic        key_pulse,
   output logic [3:0]  key_code,
   output logic [11:0] entry_bcd,
   output logic [1:0]  digit_count,
   output logic [9:0]  value,
   output logic        value_valid
);

   localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned CNT_W = $clog2(DEBOUNCE_TICKS + 1);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_TICKS);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   localparam logic [1:0] SCAN     = 2'd0;
   localparam logic [1:0] DEBOUNCE = 2'd1;
   localparam logic [1:0] HELD     = 2'd2;

   localparam logic [3:0] KEY_ENTER = 4'd10;
   localparam logic [3:0] KEY_BACK  = 4'd11;
   localparam logic [3:0] KEY_CLEAR = 4'd12;

   logic [DIV_W-1:0] div_cnt;
   logic [1:0]       row_idx, row_idx_d;
   logic [1:0]       state, state_d;
   logic [CNT_W-1:0] deb_cnt, deb_cnt_d;
   logic [3:0]       col_pat, col_pat_d;
   logic             tick;
   logic             single_low;
   logic             commit;
   logic [1:0]       col_idx;
   logic [3:0]       new_code;
   logic             enter_pend;
   logic [9:0]       bin_value;

   assign tick    = (div_cnt == DIV_LAST);
   assign key_row = ~(4'b0001 << row_idx);

   // Row/column position to key code.
   function automatic logic [3:0] map_key(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      unique case ({row, col})
         4'b00_00: code = 4'd1;
         4'b00_01: code = 4'd2;
         4'b00_10: code = 4'd3;
         4'b00_11: code = 4'd10;
         4'b01_00: code = 4'd4;
         4'b01_01: code = 4'd5;
         4'b01_10: code = 4'd6;
         4'b01_11: code = 4'd11;
         4'b10_00: code = 4'd7;
         4'b10_01: code = 4'd8;
         4'b10_10: code = 4'd9;
         4'b10_11: code = 4'd12;
         4'b11_00: code = 4'd14;
         4'b11_01: code = 4'd0;
         4'b11_10: code = 4'd15;
         default:  code = 4'd13;
      endcase
      return code;
   endfunction

   // Classify the sampled column pattern: exactly one low column, and which one.
   always_comb begin
      single_low = 1'b1;
      col_idx    = 2'd0;
      case (key_col)
         4'b1110: col_idx = 2'd0;
         4'b1101: col_idx = 2'd1;
         4'b1011: col_idx = 2'd2;
         4'b0111: col_idx = 2'd3;
         default: single_low = 1'b0;
      endcase
   end

   // At commit the live column equals the latched pattern, so decode from key_col.
   assign new_code = map_key(row_idx, col_idx);

   // Scan/debounce FSM next state; everything advances only on a scan tick.
   always_comb begin
      state_d   = state;
      deb_cnt_d = deb_cnt;
      col_pat_d = col_pat;
      row_idx_d = row_idx;
      commit    = 1'b0;
      if (tick) begin
         case (state)
            SCAN: begin
               if (single_low) begin
                  col_pat_d = key_col;
                  if (CNT_ONE >= CNT_DONE) begin
                     commit    = 1'b1;
                     deb_cnt_d = '0;
                     state_d   = HELD;
                  end else begin
                     deb_cnt_d = CNT_ONE;
                     state_d   = DEBOUNCE;
                  end
               end else begin
                  row_idx_d = row_idx + 2'd1;
               end
            end
            DEBOUNCE: begin
               if (key_col == col_pat) begin
                  if (deb_cnt + CNT_ONE >= CNT_DONE) begin
                     commit    = 1'b1;
                     deb_cnt_d = '0;
                     state_d   = HELD;
                  end else begin
                     deb_cnt_d = deb_cnt + CNT_ONE;
                  end
               end else begin
                  deb_cnt_d = '0;
                  state_d   = SCAN;
               end
            end
            HELD: begin
               // Only a run of all-high samples counts as a release.
               if (key_col == 4'hF) begin
                  if (deb_cnt + CNT_ONE >= CNT_DONE) begin
                     deb_cnt_d = '0;
                     state_d   = SCAN;
                  end else begin
                     deb_cnt_d = deb_cnt + CNT_ONE;
                  end
               end else begin
                  deb_cnt_d = '0;
               end
            end
            default: begin
               deb_cnt_d = '0;
               state_d   = SCAN;
            end
         endcase
      end
   end

   // Scan divider and FSM state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt <= '0;
         row_idx <= 2'd0;
         state   <= SCAN;
         deb_cnt <= '0;
         col_pat <= 4'hF;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
         row_idx <= row_idx_d;
         state   <= state_d;
         deb_cnt <= deb_cnt_d;
         col_pat <= col_pat_d;
      end
   end

   assign bin_value = 10'({6'd0, entry_bcd[11:8]}) * 10'd100
                    + 10'({6'd0, entry_bcd[7:4]}) * 10'd10
                    + 10'({6'd0, entry_bcd[3:0]});

   // Key commit, buffer editing and ENTER conversion (one cycle behind the commit).
   always_ff @(posedge clk) begin
      if (reset) begin
         key_pulse   <= 1'b0;
         key_code    <= 4'd0;
         entry_bcd   <= 12'h000;
         digit_count <= 2'd0;
         enter_pend  <= 1'b0;
         value       <= 10'd0;
         value_valid <= 1'b0;
      end else begin
         key_pulse   <= commit & enable;
         enter_pend  <= 1'b0;
         value_valid <= 1'b0;
         if (commit && enable) begin
            key_code <= new_code;
            if (new_code <= 4'd9) begin
               if (digit_count != 2'd3) begin
                  entry_bcd   <= {entry_bcd[7:0], new_code};
                  digit_count <= digit_count + 2'd1;
               end
            end else if (new_code == KEY_BACK) begin
               if (digit_count != 2'd0) begin
                  entry_bcd   <= {4'h0, entry_bcd[11:4]};
                  digit_count <= digit_count - 2'd1;
               end
            end else if (new_code == KEY_CLEAR) begin
               entry_bcd   <= 12'h000;
               digit_count <= 2'd0;
            end else if (new_code == KEY_ENTER) begin
               enter_pend <= (digit_count != 2'd0);
            end
         end
         if (enter_pend) begin
            value       <= bin_value;
            value_valid <= 1'b1;
            entry_bcd   <= 12'h000;
            digit_count <= 2'd0;
         end
      end
   end

endmodule

// File: tb/tb_keypad_number_entry.sv
// Directed bench for keypad_number_entry with a short scan divider.
module tb_keypad_number_entry;

   localparam int unsigned SCAN_DIV       = 4;
   localparam int unsigned DEBOUNCE_TICKS = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b1;
   logic [3:0]  key_col;
   logic [3:0]  key_row;
   logic        key_pulse;
   logic [3:0]  key_code;
   logic [11:0] entry_bcd;
   logic [1:0]  digit_count;
   logic [9:0]  value;
   logic        value_valid;

   // Keypad matrix model: pressed columns pull low only while their row is driven.
   int          press_row = 0;
   logic [3:0]  press_mask = 4'h0;
   logic [3:0]  row_sel;
   assign row_sel = ~(4'b0001 << press_row);
   assign key_col = (press_mask != 4'h0 && key_row == row_sel) ? ~press_mask : 4'hF;

   int tests_run = 0;
   int tests_failed = 0;

   int         pulse_cnt = 0;
   int         vv_cnt = 0;
   int         vv_bad = 0;
   logic [3:0] last_code = 4'd0;
   logic       vv_prev = 1'b0;
   logic       kp_prev = 1'b0;

   keypad_number_entry #(
      .SCAN_DIV       (SCAN_DIV),
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .key_col     (key_col),
      .key_row     (key_row),
      .key_pulse   (key_pulse),
      .key_code    (key_code),
      .entry_bcd   (entry_bcd),
      .digit_count (digit_count),
      .value       (value),
      .value_valid (value_valid)
   );

   always #5 clk = ~clk;

   // Strobe monitor: counts pulses, checks value_valid width and its latency after ENTER.
   always @(negedge clk) begin
      if (key_pulse) begin
         pulse_cnt = pulse_cnt + 1;
      end
      if (value_valid) begin
         vv_cnt = vv_cnt + 1;
         if (vv_prev) vv_bad = vv_bad + 1;
         if (!(kp_prev && last_code == 4'd10)) vv_bad = vv_bad + 1;
      end
      if (key_pulse) last_code = key_code;
      vv_prev = value_valid;
      kp_prev = key_pulse;
   end

   task automatic wait_ticks(input int n);
      repeat (n * SCAN_DIV) @(negedge clk);
   endtask

   task automatic tap(input int r, input int c);
      press_row  = r;
      press_mask = 4'b0001 << c;
      wait_ticks(16);
      press_mask = 4'h0;
      wait_ticks(8);
   endtask

   // Wait for the scan to step onto row 0; the next tick is then SCAN_DIV clocks away.
   task automatic align_row0();
      logic [3:0] prev;
      logic       found;
      found = 1'b0;
      prev  = key_row;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (key_row == 4'b1110 && prev != 4'b1110) found = 1'b1;
         prev = key_row;
      end
      tests_run++;
      if (!found) begin
         tests_failed++;
         $display("FAIL align_row0: row 0 not reached, key_row=%b", key_row);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      tests_run++;
      if (key_row !== 4'b1110 || value !== 10'd0 || value_valid !== 1'b0 ||
          digit_count !== 2'd0 || entry_bcd !== 12'h000 || key_pulse !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset: row=%b value=%0d vv=%b cnt=%0d bcd=%h kp=%b, want 1110/0/0/0/000/0",
                  key_row, value, value_valid, digit_count, entry_bcd, key_pulse);
      end
      reset = 1'b0;
      @(negedge clk);
      tests_run++;
      if (key_row !== 4'b1110) begin
         tests_failed++;
         $display("FAIL reset_release_row: got %b want 1110", key_row);
      end
   endtask

   task automatic test_hold_single();
      int p0;
      p0 = pulse_cnt;
      press_row  = 1;
      press_mask = 4'b0010;
      wait_ticks(40);
      press_mask = 4'h0;
      wait_ticks(8);
      tests_run++;
      if (pulse_cnt - p0 != 1) begin
         tests_failed++;
         $display("FAIL hold_one_pulse: got %0d pulses want 1", pulse_cnt - p0);
      end
      tests_run++;
      if (key_code !== 4'd5 || entry_bcd !== 12'h005 || digit_count !== 2'd1) begin
         tests_failed++;
         $display("FAIL hold_entry: code=%0d bcd=%h cnt=%0d want 5/005/1",
                  key_code, entry_bcd, digit_count);
      end
   endtask

   task automatic test_bounce();
      int p0;
      p0 = pulse_cnt;
      align_row0();
      press_row  = 0;
      press_mask = 4'b0001;
      repeat (2 * SCAN_DIV) @(negedge clk);
      press_mask = 4'h0;
      wait_ticks(2);
      tests_run++;
      if (pulse_cnt != p0) begin
         tests_failed++;
         $display("FAIL bounce_short: got %0d pulses want 0", pulse_cnt - p0);
      end
      align_row0();
      press_mask = 4'b0001;
      repeat (4 * SCAN_DIV - 1) @(negedge clk);
      tests_run++;
      if (key_pulse !== 1'b0 || pulse_cnt != p0) begin
         tests_failed++;
         $display("FAIL bounce_early: kp=%b pulses=%0d want 0/0", key_pulse, pulse_cnt - p0);
      end
      @(negedge clk);
      tests_run++;
      if (key_pulse !== 1'b1 || key_code !== 4'd1) begin
         tests_failed++;
         $display("FAIL bounce_commit: kp=%b code=%0d want 1/1", key_pulse, key_code);
      end
      @(negedge clk);
      tests_run++;
      if (key_pulse !== 1'b0) begin
         tests_failed++;
         $display("FAIL bounce_pulse_width: kp=%b want 0", key_pulse);
      end
      wait_ticks(6);
      press_mask = 4'h0;
      wait_ticks(8);
      tests_run++;
      if (pulse_cnt - p0 != 1 || entry_bcd !== 12'h051 || digit_count !== 2'd2) begin
         tests_failed++;
         $display("FAIL bounce_entry: pulses=%0d bcd=%h cnt=%0d want 1/051/2",
                  pulse_cnt - p0, entry_bcd, digit_count);
      end
   endtask

   task automatic test_enter_123();
      int p0, v0;
      tap(2, 3);
      tests_run++;
      if (entry_bcd !== 12'h000 || digit_count !== 2'd0) begin
         tests_failed++;
         $display("FAIL clear: bcd=%h cnt=%0d want 000/0", entry_bcd, digit_count);
      end
      tap(0, 0);
      tap(0, 1);
      tap(0, 2);
      tests_run++;
      if (entry_bcd !== 12'h123 || digit_count !== 2'd3) begin
         tests_failed++;
         $display("FAIL three_digits: bcd=%h cnt=%0d want 123/3", entry_bcd, digit_count);
      end
      p0 = pulse_cnt;
      tap(1, 0);
      tests_run++;
      if (pulse_cnt - p0 != 1 || key_code !== 4'd4 || entry_bcd !== 12'h123 ||
          digit_count !== 2'd3) begin
         tests_failed++;
         $display("FAIL fourth_digit: pulses=%0d code=%0d bcd=%h cnt=%0d want 1/4/123/3",
                  pulse_cnt - p0, key_code, entry_bcd, digit_count);
      end
      v0 = vv_cnt;
      tap(0, 3);
      tests_run++;
      if (vv_cnt - v0 != 1 || value !== 10'd123 || entry_bcd !== 12'h000 ||
          digit_count !== 2'd0 || vv_bad != 0) begin
         tests_failed++;
         $display("FAIL enter_123: vv=%0d value=%0d bcd=%h cnt=%0d bad=%0d want 1/123/000/0/0",
                  vv_cnt - v0, value, entry_bcd, digit_count, vv_bad);
      end
   endtask

   task automatic test_edit_ops();
      int p0, v0;
      tap(2, 2);
      tap(2, 1);
      tap(1, 3);
      tests_run++;
      if (entry_bcd !== 12'h009 || digit_count !== 2'd1) begin
         tests_failed++;
         $display("FAIL backspace: bcd=%h cnt=%0d want 009/1", entry_bcd, digit_count);
      end
      v0 = vv_cnt;
      tap(2, 0);
      tap(0, 3);
      tests_run++;
      if (vv_cnt - v0 != 1 || value !== 10'd97 || vv_bad != 0) begin
         tests_failed++;
         $display("FAIL enter_97: vv=%0d value=%0d bad=%0d want 1/97/0",
                  vv_cnt - v0, value, vv_bad);
      end
      tap(1, 0);
      v0 = vv_cnt;
      p0 = pulse_cnt;
      tap(2, 3);
      tap(0, 3);
      tests_run++;
      if (vv_cnt != v0 || pulse_cnt - p0 != 2 || value !== 10'd97) begin
         tests_failed++;
         $display("FAIL empty_enter: vv=%0d pulses=%0d value=%0d want 0/2/97",
                  vv_cnt - v0, pulse_cnt - p0, value);
      end
      enable = 1'b0;
      p0 = pulse_cnt;
      tap(1, 1);
      enable = 1'b1;
      tests_run++;
      if (pulse_cnt != p0 || entry_bcd !== 12'h000 || digit_count !== 2'd0) begin
         tests_failed++;
         $display("FAIL disabled_key: pulses=%0d bcd=%h cnt=%0d want 0/000/0",
                  pulse_cnt - p0, entry_bcd, digit_count);
      end
   endtask

   task automatic test_boundaries();
      int p0;
      p0 = pulse_cnt;
      press_row  = 2;
      press_mask = 4'b0011;
      wait_ticks(24);
      press_mask = 4'h0;
      wait_ticks(8);
      tests_run++;
      if (pulse_cnt != p0) begin
         tests_failed++;
         $display("FAIL two_cols: got %0d pulses want 0", pulse_cnt - p0);
      end
      align_row0();
      press_row  = 0;
      press_mask = 4'b0001;
      repeat (2 * SCAN_DIV) @(negedge clk);
      reset      = 1'b1;
      press_mask = 4'h0;
      repeat (2) @(negedge clk);
      tests_run++;
      if (key_row !== 4'b1110 || key_pulse !== 1'b0 || value !== 10'd0) begin
         tests_failed++;
         $display("FAIL reset_mid_debounce: row=%b kp=%b value=%0d want 1110/0/0",
                  key_row, key_pulse, value);
      end
      reset = 1'b0;
      wait_ticks(12);
      tests_run++;
      if (pulse_cnt != p0 || entry_bcd !== 12'h000 || value_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_discard: pulses=%0d bcd=%h vv=%b want 0/000/0",
                  pulse_cnt - p0, entry_bcd, value_valid);
      end
      tap(3, 1);
      tests_run++;
      if (pulse_cnt - p0 != 1 || key_code !== 4'd0 || entry_bcd !== 12'h000 ||
          digit_count !== 2'd1) begin
         tests_failed++;
         $display("FAIL after_reset_zero: pulses=%0d code=%0d bcd=%h cnt=%0d want 1/0/000/1",
                  pulse_cnt - p0, key_code, entry_bcd, digit_count);
      end
   endtask

   initial begin
      test_reset();
      test_hold_single();
      test_bounce();
      test_enter_123();
      test_edit_ops();
      test_boundaries();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
